arb_mux_rr: RTL and testbench

Parametrised, registered N-to-1 multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output. It generalises the combinational 4:1 select mux. Instead of an external select, it picks among requesting channels fairly and buffers the winner in one output register. It sits where the two cores and auxiliary masters share a single downstream port, such as the shared memory or bus request path.

---
 rtl/arb_mux_rr_pkg.sv | 30 +++
 rtl/arb_mux_rr_if.sv | 42 ++++
 rtl/arb_mux_rr_arbiter.sv | 67 ++++++
 rtl/arb_mux_rr.sv | 61 ++++++
 tb/tb_arb_mux_rr.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_mux_rr_pkg.sv
// Shared definitions for the round-robin arbitrated output mux (arb_mux_rr).
// Provides default sizes and the round-robin pick function used by rr_arbiter.
package arb_mux_pkg;

    localparam int ARB_NUM_CH_DEF = 4;
    localparam int ARB_DATA_W_DEF = 8;

    // Upper bound on channel count supported by rr_pick.
    localparam int ARB_MAX_CH    = 32;
    localparam int ARB_MAX_IDX_W = 5;

    typedef logic [ARB_MAX_CH-1:0] req_vec_t;

    // One-hot grant: first set bit of req searching upward from (ptr+1) mod num_ch,
    // wrapping around; zero when no bit within num_ch is set.
    function automatic req_vec_t rr_pick(input req_vec_t    req,
                                         input int unsigned ptr,
                                         input int unsigned num_ch);
        req_vec_t    gnt;
        int unsigned idx;
        gnt = '0;
        for (int unsigned k = 1; k <= ARB_MAX_CH; k++) begin
            idx = (ptr + k) % num_ch;
            if ((k <= num_ch) && (gnt == '0) && req[idx[ARB_MAX_IDX_W-1:0]])
                gnt[idx[ARB_MAX_IDX_W-1:0]] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/arb_mux_rr_if.sv
// Handshake bundle for arb_mux_rr: N request channels in, one buffered channel out.
// in_lock is present only when ARB_MUX_LOCK_EN is defined.
interface arb_mux_rr_if
    import arb_mux_pkg::*;
#(
    parameter int NUM_CH = ARB_NUM_CH_DEF,
    parameter int DATA_W = ARB_DATA_W_DEF
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
`ifdef ARB_MUX_LOCK_EN
    logic [NUM_CH-1:0]        in_lock;

    modport master (
        output in_data, in_valid, in_lock, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, in_lock, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
`endif

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant generation with last-winner pointer.
// With ARB_MUX_LOCK_EN defined, a transfer carrying its lock bit pins the grant
// to that channel until it transfers again with the lock bit clear.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int NUM_CH = ARB_NUM_CH_DEF,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0] lock_req,
`endif
    input  logic              load,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;

`ifdef ARB_MUX_LOCK_EN
    logic            locked;
    logic [CH_W-1:0] lock_ch;
`endif

    // Grant search starts just past the last winner; a held lock overrides it.
    always_comb begin
        grant = NUM_CH'(rr_pick(req_vec_t'(req), 32'(ptr), NUM_CH));
`ifdef ARB_MUX_LOCK_EN
        if (locked) begin
            grant          = '0;
            grant[lock_ch] = req[lock_ch];
        end
`endif
    end

    // Binary index of the one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant[i]) grant_idx = CH_W'(i);
    end

    // Remember the winner of each transfer; reset value favours channel 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= CH_W'(NUM_CH - 1);
        else if (load && |grant)
            ptr <= grant_idx;
    end

`ifdef ARB_MUX_LOCK_EN
    // Lock follows the lock bit of whichever channel just transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (load && |grant) begin
            locked  <= lock_req[grant_idx];
            lock_ch <= grant_idx;
        end
    end
`endif

endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-to-1 registered mux with round-robin arbitration and
// valid/ready on every channel. One output register; drain and refill may
// happen in the same cycle. Optional feature macro: ARB_MUX_LOCK_EN.
module arb_mux_rr
    import arb_mux_pkg::*;
#(
    parameter  int NUM_CH = ARB_NUM_CH_DEF,
    parameter  int DATA_W = ARB_DATA_W_DEF,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic         clk,
    input  logic         rst_n,
    arb_mux_rr_if.slave  bus
);

    logic              load;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [DATA_W-1:0] sel_data;

    // Output register can take a word when empty or being drained this cycle.
    assign load        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = load ? grant : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.in_valid),
`ifdef ARB_MUX_LOCK_EN
        .lock_req  (bus.in_lock),
`endif
        .load      (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // AND-OR data select driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant[i]) sel_data = bus.in_data[i*DATA_W +: DATA_W];
    end

    // Output buffer: capture the winner, or go empty when loading with no winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
        end else if (load) begin
            bus.out_valid <= |grant;
            if (|grant) begin
                bus.out_data <= sel_data;
                bus.out_ch   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Scoreboard bench for arb_mux_rr: the driver runs a behavioural model that
// predicts in_ready and queues expected output words; a monitor pops and
// compares whenever the output handshake completes.
module tb_arb_mux_rr;
    import arb_mux_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
`ifdef ARB_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        int                ch;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_mux_rr_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    arb_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    // Reference model state
    int m_ptr;
    bit m_full;
    int m_acc;
    bit m_locked;
    int m_lock_ch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr     = NUM_CH - 1;
        m_full    = 1'b0;
        m_acc     = -1;
        m_locked  = 1'b0;
        m_lock_ch = 0;
    endtask

    // First valid channel after the previous winner, wrapping; -1 if none.
    function automatic int model_pick(input logic [NUM_CH-1:0] v);
        if (m_locked) return v[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock of stimulus plus model prediction.
    task automatic do_cycle(input logic [NUM_CH-1:0]        v,
                            input logic [NUM_CH*DATA_W-1:0] d,
                            input logic                     rdy,
                            input logic [NUM_CH-1:0]        lk);
        int                g;
        bit                ld;
        logic [NUM_CH-1:0] exp_rdy;
        exp_t              e;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
`ifdef ARB_MUX_LOCK_EN
        bus.in_lock   = lk;
`endif
        #2;
        ld      = !m_full || rdy;
        g       = model_pick(v);
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        m_acc = -1;
        if (ld) begin
            if (g >= 0) begin
                e.data = d[g*DATA_W +: DATA_W];
                e.ch   = g;
                exp_q.push_back(e);
                m_ptr  = g;
                m_full = 1'b1;
                m_acc  = g;
                if (LOCK_EN) begin
                    m_locked  = lk[g];
                    m_lock_ch = g;
                end
            end else begin
                m_full = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: each completed output handshake must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_empty: got out_data %0h with no expected word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.data));
                    chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
                end
            end
        end
    end

    localparam logic [NUM_CH*DATA_W-1:0] ALL_D = 32'h1312_1110;

    initial begin
        logic [NUM_CH-1:0]        pv;
        logic [NUM_CH*DATA_W-1:0] pd;
        logic [NUM_CH-1:0]        lk;

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
        bus.in_lock   = '0;
`endif
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        chk("reset_out_ch", 32'(bus.out_ch), 32'd0);
        #1;
        rst_n = 1'b1;

        // Single requester ch2 with 0xA5, then let it drain.
        do_cycle(4'b0100, 32'h00A5_0000, 1'b1, 4'b0000);
        do_cycle(4'b0000, 32'h0, 1'b1, 4'b0000);

        // All channels valid: fair rotation 0,1,2,3,0.
        do_reset();
        repeat (5) do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);

        // Stall with 0x11 held for three cycles, then resume with 0x12.
        do_reset();
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        repeat (3) do_cycle(4'b1111, ALL_D, 1'b0, 4'b0000);
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b0000, ALL_D, 1'b1, 4'b0000);

        // Wrap-around: ptr=0, then ch0 and ch3 requesting -> ch3 then ch0.
        do_reset();
        do_cycle(4'b0001, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b1001, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b1001, ALL_D, 1'b1, 4'b0000);

        // Reset while a word is buffered, then lowest valid channel wins.
        do_cycle(4'b0010, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b0000, ALL_D, 1'b0, 4'b0000);
        do_reset();
        do_cycle(4'b1010, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b0000, ALL_D, 1'b1, 4'b0000);

`ifdef ARB_MUX_LOCK_EN
        // Lock on ch1 for three further grants, release, then ch2.
        do_reset();
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        repeat (3) do_cycle(4'b1111, ALL_D, 1'b1, 4'b0010);
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b1111, ALL_D, 1'b1, 4'b0000);
        do_cycle(4'b0000, ALL_D, 1'b1, 4'b0000);
`endif

        // Randomised traffic; requests hold until accepted.
        do_reset();
        pv = '0;
        pd = '0;
        for (int n = 0; n < 2000; n++) begin
            lk = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pv[i] && ($urandom_range(0, 99) < 50)) begin
                    pv[i] = 1'b1;
                    pd[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
                lk[i] = ($urandom_range(0, 9) == 0);
            end
            do_cycle(pv, pd, ($urandom_range(0, 3) != 0), lk);
            if (m_acc >= 0) pv[m_acc] = 1'b0;
        end

        // Drain and confirm nothing expected is left behind.
        repeat (4) do_cycle(4'b0000, pd, 1'b1, 4'b0000);
        @(negedge clk);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
